uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter (8N1, same baud generator as the receiver path) among NUM_REQ requesters using round-robin arbitration.
- Latches the winner's byte, pulses the transmitter start and waits for its done pulse.
- Returns a one-cycle ack to the winner.
- A watchdog aborts a transfer whose done pulse never arrives, so one stuck transfer cannot block the others.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encoding, frame shape and
// small helpers used by the transmit arbiter.
package uart_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;
    localparam int CLK_FREQ   = 50_000_000;
    localparam int MAX_REQ    = 8;

    typedef logic [1:0]           state_t;
    typedef logic [DATA_BITS-1:0] byte_t;

    // One-hot of an index for up to MAX_REQ requesters; callers truncate.
    function automatic logic [MAX_REQ-1:0] onehot8(input logic [2:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

    // Clock cycles one full frame occupies at a given baud rate.
    function automatic int frame_cycles(input int baud);
        return (CLK_FREQ / baud) * FRAME_BITS;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request after the
// last-served index, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi+1 positions after last; the sum stays
    // below 2*NUM_REQ, so one conditional subtract wraps it.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;
        assign sum           = {1'b0, last} + SUM_W'(gi + 1);
        assign cand_idx[gi]  = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                         : sum[IDX_W-1:0];
        assign cand_hit[gi]  = req[cand_idx[gi]];
    end

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand_idx[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ
// requesters, with a watchdog that aborts transfers whose done never arrives.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 65536,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic [IDX_W-1:0]       err_id,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);

    state_t               state_reg;
    logic [NUM_REQ-1:0]   grant_reg;
    logic [NUM_REQ-1:0]   ack_reg;
    logic                 err_reg;
    logic [IDX_W-1:0]     err_id_reg;
    logic                 tx_start_reg;
    byte_t                tx_data_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [IDX_W-1:0]     last_reg;
    logic [WD_W-1:0]      wd_reg;

    byte_t                req_byte [NUM_REQ];
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 wd_expired;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign req_byte[gi] = req_data[DATA_BITS*gi +: DATA_BITS];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .last   (last_reg),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign wd_expired = (wd_reg == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            ack_reg      <= '0;
            err_reg      <= 1'b0;
            err_id_reg   <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            idx_reg      <= '0;
            last_reg     <= IDX_W'(NUM_REQ - 1);
            wd_reg       <= '0;
        end else begin
            // Pulsed outputs default low; each state raises them for one cycle.
            tx_start_reg <= 1'b0;
            ack_reg      <= '0;
            err_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (en && !tx_busy && pick_valid) begin
                        grant_reg    <= NUM_REQ'(onehot8(3'(pick_idx)));
                        tx_data_reg  <= req_byte[pick_idx];
                        tx_start_reg <= 1'b1;
                        idx_reg      <= pick_idx;
                        state_reg    <= START;
                    end
                end
                START: begin
                    wd_reg    <= '0;
                    state_reg <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    wd_reg <= wd_reg + 1'b1;
                    // A done arriving on the expiry cycle still counts as success.
                    if (tx_done) begin
                        ack_reg   <= NUM_REQ'(onehot8(3'(idx_reg)));
                        grant_reg <= '0;
                        last_reg  <= idx_reg;
                        state_reg <= IDLE;
                    end else if (wd_expired) begin
                        err_reg    <= 1'b1;
                        err_id_reg <= idx_reg;
                        grant_reg  <= '0;
                        last_reg   <= idx_reg;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_reg;
    assign ack      = ack_reg;
    assign err      = err_reg;
    assign err_id   = err_id_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single transfer, round-robin order,
// data latching, watchdog abort, done/timeout collision, gating and reset.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        err;
    logic [1:0]  err_id;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .ack      (ack),
        .err      (err),
        .err_id   (err_id),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One edge later the winner must be granted with tx_start high.
    task automatic expect_grant(input string tag, input logic [3:0] g, input logic [7:0] d);
        @(negedge clk);
        check_eq({tag, ".start"}, tx_start, 1);
        check_eq({tag, ".grant"}, grant, g);
        check_eq({tag, ".data"}, tx_data, d);
    endtask

    // Called in the tx_start cycle S; pulses tx_done in cycle S+k, expects ack in S+k+1.
    task automatic finish_xfer(input string tag, input int k, input logic [3:0] a,
                               input logic [7:0] d, input logic [3:0] next_req);
        @(negedge clk);
        check_eq({tag, ".start_low"}, tx_start, 0);
        repeat (k - 1) @(negedge clk);
        check_eq({tag, ".data_hold"}, tx_data, d);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq({tag, ".ack"}, ack, a);
        check_eq({tag, ".no_err"}, err, 0);
        check_eq({tag, ".grant_off"}, grant, 0);
        $display("xfer %s: ack=%b data=%h", tag, ack, tx_data);
        req = next_req;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst.grant", grant, 0);
        check_eq("rst.ack", ack, 0);
        check_eq("rst.err", err, 0);
        check_eq("rst.start", tx_start, 0);
        check_eq("rst.data", tx_data, 0);
        rst = 1'b0;

        // Single request from requester 1
        req_data = 32'h0000_A500;
        req = 4'b0010;
        expect_grant("single", 4'b0010, 8'hA5);
        finish_xfer("single", 10, 4'b0010, 8'hA5, 4'b0000);

        // Round-robin from a fresh reset: 0,1,2,3,0
        pulse_reset();
        req_data = 32'h4433_2211;
        req = 4'b1111;
        expect_grant("rr0", 4'b0001, 8'h11);
        finish_xfer("rr0", 5, 4'b0001, 8'h11, 4'b1111);
        expect_grant("rr1", 4'b0010, 8'h22);
        finish_xfer("rr1", 5, 4'b0010, 8'h22, 4'b1111);
        expect_grant("rr2", 4'b0100, 8'h33);
        finish_xfer("rr2", 5, 4'b0100, 8'h33, 4'b1111);
        expect_grant("rr3", 4'b1000, 8'h44);
        finish_xfer("rr3", 5, 4'b1000, 8'h44, 4'b1111);
        expect_grant("rr4", 4'b0001, 8'h11);
        finish_xfer("rr4", 5, 4'b0001, 8'h11, 4'b0000);

        // Data latched at the grant edge only
        req_data = 32'h0000_005A;
        req = 4'b0001;
        expect_grant("stab", 4'b0001, 8'h5A);
        req_data = 32'h0000_00C3;
        finish_xfer("stab", 6, 4'b0001, 8'h5A, 4'b0000);

        // Watchdog: requester 2 never gets done; requester 1 queued behind it
        req_data = 32'h0077_6600;
        req = 4'b0100;
        expect_grant("wd", 4'b0100, 8'h77);
        req = 4'b0110;
        repeat (TO) @(negedge clk);
        check_eq("wd.err_early", err, 0);
        check_eq("wd.grant_held", grant, 4'b0100);
        @(negedge clk);
        check_eq("wd.err", err, 1);
        check_eq("wd.err_id", err_id, 2);
        check_eq("wd.no_ack", ack, 0);
        check_eq("wd.grant_off", grant, 0);
        $display("xfer wd: err=%b err_id=%0d", err, err_id);
        req = 4'b0010;
        expect_grant("wd_next", 4'b0010, 8'h66);
        finish_xfer("wd_next", 3, 4'b0010, 8'h66, 4'b0000);
        check_eq("wd.err_id_hold", err_id, 2);

        // done on the same cycle the watchdog would expire
        req_data = 32'h0000_009E;
        req = 4'b0001;
        expect_grant("coll", 4'b0001, 8'h9E);
        finish_xfer("coll", TO, 4'b0001, 8'h9E, 4'b0000);

        // en low blocks grants; dropping en mid-transfer does not
        req_data = 32'h0000_00E1;
        en = 1'b0;
        req = 4'b0001;
        repeat (3) @(negedge clk);
        check_eq("en0.grant", grant, 0);
        check_eq("en0.start", tx_start, 0);
        en = 1'b1;
        expect_grant("en1", 4'b0001, 8'hE1);
        en = 1'b0;
        finish_xfer("en_mid", 4, 4'b0001, 8'hE1, 4'b0000);
        en = 1'b1;

        // tx_busy in IDLE stalls arbitration
        req_data = 32'h0000_B20D;
        tx_busy = 1'b1;
        req = 4'b0010;
        repeat (3) @(negedge clk);
        check_eq("busy.grant", grant, 0);
        tx_busy = 1'b0;
        expect_grant("busy", 4'b0010, 8'hB2);

        // Reset in WAIT_DONE, then a stray done, then requester 0 first
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst.grant", grant, 0);
        check_eq("mrst.ack", ack, 0);
        check_eq("mrst.start", tx_start, 0);
        check_eq("mrst.data", tx_data, 0);
        check_eq("mrst.err", err, 0);
        check_eq("mrst.err_id", err_id, 0);
        rst = 1'b0;
        req = 4'b0000;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("stray.ack", ack, 0);
        check_eq("stray.grant", grant, 0);
        req = 4'b0011;
        expect_grant("post0", 4'b0001, 8'h0D);
        finish_xfer("post0", 4, 4'b0001, 8'h0D, 4'b0010);
        expect_grant("post1", 4'b0010, 8'hB2);
        finish_xfer("post1", 4, 4'b0010, 8'hB2, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
